mem_port_arbiter: RTL and testbench

//  Shares the single DataMem backing port between the L1 data-cache miss/writeback port (req 0)
//  and the instruction-fetch refill port (req 1). Latches one request at a time, sequences it

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_rr.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_arb_pkg                                                      |
// | Brief   : Shared types and constants for the DataMem port arbiter.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  // Requester identifiers
  localparam logic REQ_DATA  = 1'b0;
  localparam logic REQ_FETCH = 1'b1;

  // Access size used for every fetch refill (full word)
  localparam logic [2:0] WORD_FUNCT3 = 3'b010;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_arb_rr                                                       |
// | Brief   : Two-way round-robin picker. Combinational grant; the priority    |
// |           pointer moves to the other requester whenever a grant is taken.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant
);

  logic ptr;

  // Pick: a lone requester wins outright, a tie goes to the pointer owner
  always_comb begin
    grant_valid = |req;
    grant       = REQ_DATA;
    if (req == 2'b11) begin
      grant = ptr;
    end else if (req[1]) begin
      grant = REQ_FETCH;
    end
  end

  // Pointer: after any taken grant, favour the requester that did not win
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= REQ_DATA;
    end else if (advance && grant_valid) begin
      ptr <= ~grant;
    end
  end

endmodule : mem_arb_rr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                                 |
// | Brief   : Shares the DataMem port between the data cache (req 0) and the   |
// |           fetch refill path (req 1); one fixed-latency access at a time.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [2:0]            d_funct3,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  // Counter preload: ACCESS runs from this value down to zero inclusive
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  arb_state_t            state;
  arb_state_t            state_next;
  logic [1:0]            req;
  logic                  grant_valid;
  logic                  grant_id;
  logic                  take;
  logic                  id_q;
  logic                  is_write_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [2:0]            funct3_q;
  logic [3:0]            cnt;

  // A simultaneous read+write from the data cache is a single request treated as a write
  assign req  = {i_read, d_read | d_write};
  assign take = (state == ARB_IDLE) && grant_valid;

  mem_arb_rr u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .advance     (take),
    .grant_valid (grant_valid),
    .grant       (grant_id)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: IDLE -> ACCESS on any request, ACCESS until counter expires, DONE for one cycle
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:   if (grant_valid) state_next = ARB_ACCESS;
      ARB_ACCESS: if (cnt == 4'd0) state_next = ARB_DONE;
      ARB_DONE:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // Request latches, latency counter and read-data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q       <= REQ_DATA;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
    end else if (take) begin
      id_q    <= grant_id;
      cnt     <= CNT_INIT;
      rdata_q <= '0;
      if (grant_id == REQ_FETCH) begin
        // Fetch refills are always aligned word reads
        addr_q     <= {i_addr[DATA_WIDTH-1:2], 2'b00};
        wdata_q    <= '0;
        funct3_q   <= WORD_FUNCT3;
        is_write_q <= 1'b0;
      end else begin
        addr_q     <= d_addr;
        wdata_q    <= d_wdata;
        funct3_q   <= d_funct3;
        is_write_q <= d_write;
      end
    end else if (state == ARB_ACCESS) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (!is_write_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs: memory bus only during ACCESS, ready/rdata only during DONE for the owner
  always_comb begin
    busy       = (state != ARB_IDLE);
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    d_ready    = 1'b0;
    d_rdata    = '0;
    i_ready    = 1'b0;
    i_rdata    = '0;
    case (state)
      ARB_ACCESS: begin
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_funct3 = funct3_q;
        // Single write strobe on the first ACCESS cycle only
        mem_write  = is_write_q && (cnt == CNT_INIT);
      end
      ARB_DONE: begin
        if (id_q == REQ_FETCH) begin
          i_ready = 1'b1;
          i_rdata = rdata_q;
        end else begin
          d_ready = 1'b1;
          d_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_port_arbiter                                              |
// | Brief   : Directed bench for mem_port_arbiter with a transaction-timeline  |
// |           reference model checked every cycle.                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_read, d_write, i_read;
  logic [DW-1:0] d_addr, d_wdata, i_addr, mem_rdata;
  logic [2:0]    d_funct3;
  logic          d_ready, i_ready, mem_write, busy;
  logic [DW-1:0] d_rdata, i_rdata, mem_addr, mem_wdata;
  logic [2:0]    mem_funct3;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_pulses = 0;
  logic [DW-1:0] wr_addr_seen = '0;
  logic [DW-1:0] wr_data_seen = '0;
  logic started = 1'b0;

  mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_funct3   (d_funct3),
    .d_ready    (d_ready),
    .d_rdata    (d_rdata),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_ready    (i_ready),
    .i_rdata    (i_rdata),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one transaction on a timeline ----------
  // A granted transaction is aged in cycles since its grant edge: ages 1..L are
  // the memory access window, age L+1 is the completion cycle.
  logic          m_active = 1'b0;
  int            m_age = 0;
  logic          m_id = 1'b0;
  logic          m_wr = 1'b0;
  logic          m_ptr = 1'b0;
  logic [DW-1:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [2:0]    m_f3 = '0;
  logic          r0, r1, m_pick;

  assign r0     = d_read | d_write;
  assign r1     = i_read;
  assign m_pick = (r0 && r1) ? m_ptr : r1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_ptr    <= 1'b0;
      m_age    <= 0;
    end else if (m_active) begin
      if (m_age == L + 1) begin
        m_active <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age == L && !m_wr) m_rdata <= mem_rdata;
      end
    end else if (r0 || r1) begin
      m_active <= 1'b1;
      m_age    <= 1;
      m_id     <= m_pick;
      m_ptr    <= ~m_pick;
      m_rdata  <= '0;
      if (m_pick) begin
        m_addr  <= i_addr & ~32'h3;
        m_wdata <= '0;
        m_f3    <= 3'b010;
        m_wr    <= 1'b0;
      end else begin
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_f3    <= d_funct3;
        m_wr    <= d_write;
      end
    end
  end

  logic e_acc, e_done;
  assign e_acc  = m_active && (m_age >= 1) && (m_age <= L);
  assign e_done = m_active && (m_age == L + 1);

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("busy",       32'(busy),       32'(m_active));
      chk("d_ready",    32'(d_ready),    32'(e_done && !m_id));
      chk("i_ready",    32'(i_ready),    32'(e_done && m_id));
      chk("d_rdata",    d_rdata,         (e_done && !m_id) ? m_rdata : '0);
      chk("i_rdata",    i_rdata,         (e_done && m_id) ? m_rdata : '0);
      chk("mem_write",  32'(mem_write),  32'(e_acc && m_wr && m_age == 1));
      chk("mem_addr",   mem_addr,        e_acc ? m_addr : '0);
      chk("mem_funct3", 32'(mem_funct3), e_acc ? 32'(m_f3) : 32'd0);
      if (!(e_acc && m_id)) chk("mem_wdata", mem_wdata, e_acc ? m_wdata : '0);
    end
  end

  // Cycle stamp and write-strobe monitor
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      wr_pulses    <= wr_pulses + 1;
      wr_addr_seen <= mem_addr;
      wr_data_seen <= mem_wdata;
    end
  end

  // Waits for any ready pulse; n counts negedges from the call, 0 on timeout
  task automatic wait_any(output int n, output logic who);
    n   = 0;
    who = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_ready === 1'b1 || i_ready === 1'b1) begin
        n   = k;
        who = (i_ready === 1'b1);
        break;
      end
    end
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got no ready within 20 cycles, required one pulse");
    end
  endtask

  task automatic drive_idle();
    d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
    d_addr = '0; d_wdata = '0; d_funct3 = '0; i_addr = '0;
  endtask

  // Hard stop in case something waits forever outside the bounded loops
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  int          n, w0;
  logic        who, exp_who;
  int          stamp [4];

  initial begin
    drive_idle();
    mem_rdata = '0;
    // Reset held two cycles with a data read pending
    rst_n  = 1'b0;
    d_read = 1'b1;
    @(posedge clk); #2;
    started = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_d_ready",   32'(d_ready),   32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_mem_addr",  mem_addr,       32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #2;

    // Single read: ready on the 3rd cycle after the request edge, i.e. the
    // 4th negedge counted from the drive point (one idle negedge first)
    d_read = 1'b1; d_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    wait_any(n, who);
    chk("read_latency", n,               32'd4);
    chk("read_owner",   32'(who),        32'd0);
    chk("read_rdata",   d_rdata,         32'hDEADBEEF);
    chk("read_i_ready", 32'(i_ready),    32'd0);
    @(posedge clk); #2;
    drive_idle();
    repeat (2) @(posedge clk);
    #2;

    // Write: one strobe, d_rdata zero even with nonzero memory read data
    w0 = wr_pulses;
    d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_funct3 = 3'b010;
    mem_rdata = 32'h5555AAAA;
    wait_any(n, who);
    chk("write_latency", n,        32'd4);
    chk("write_owner",   32'(who), 32'd0);
    chk("write_rdata",   d_rdata,  32'd0);
    @(posedge clk); #2;
    drive_idle();
    chk("write_pulses",  wr_pulses - w0, 32'd1);
    chk("write_addr",    wr_addr_seen,   32'h200);
    chk("write_data",    wr_data_seen,   32'h12345678);
    @(negedge clk);
    chk("write_ready_once", 32'(d_ready), 32'd0);

    // Contention from reset: grants alternate 0,1,0,1 every 4 cycles
    @(posedge clk); #2;
    rst_n = 1'b0; d_read = 1'b1; i_read = 1'b1;
    d_addr = 32'h40; i_addr = 32'h80; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_who = 1'b0;
    for (int p = 0; p < 4; p++) begin
      wait_any(n, who);
      chk("contention_owner", 32'(who), 32'(exp_who));
      stamp[p] = cyc;
      if (p > 0) chk("contention_spacing", stamp[p] - stamp[p-1], 32'd4);
      exp_who = ~exp_who;
    end
    @(posedge clk); #2;
    drive_idle();
    repeat (2) @(posedge clk);
    #2;

    // Fetch alignment
    i_read = 1'b1; i_addr = 32'h0000_0103; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    chk("fetch_addr",   mem_addr,          32'h100);
    chk("fetch_funct3", 32'(mem_funct3),   32'd2);
    wait_any(n, who);
    chk("fetch_latency", n,        32'd2);
    chk("fetch_owner",   32'(who), 32'd1);
    chk("fetch_rdata",   i_rdata,  32'hCAFEF00D);
    @(posedge clk); #2;
    drive_idle();
    repeat (2) @(posedge clk);
    #2;

    // Reset during the second ACCESS cycle of a read
    d_read = 1'b1; d_addr = 32'h300; mem_rdata = 32'h11112222;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0; d_read = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy_after", 32'(busy),    32'd0);
    chk("abort_no_ready",   32'(d_ready), 32'd0);
    @(posedge clk); #2;
    // Pointer must be back at req 0: a tie goes to the data cache
    d_read = 1'b1; i_read = 1'b1; d_addr = 32'h304; i_addr = 32'h500;
    mem_rdata = 32'h33334444;
    wait_any(n, who);
    chk("post_reset_owner", 32'(who), 32'd0);
    chk("post_reset_rdata", d_rdata,  32'h33334444);
    @(posedge clk); #2;
    drive_idle();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
